// File: rtl/bf_pkg.sv
// Shared types and width helpers for the delay-and-sum beamformer.
// Holds no logic, so it adds no latency and has no flow control of its own.
package bf_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int sum_width(input int data_w, input int num_ch);
        return data_w + $clog2(num_ch);
    endfunction

    function automatic int idx_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int BF_NUM_CH_DEF = 16;
    localparam int BF_IDX_W      = idx_width(BF_NUM_CH_DEF);

endpackage

// File: rtl/bf_delay_line.sv
// One channel's circular frame history: registered write, combinational read.
// Latency: 0 cycles to read; the write lands at the clock edge. No backpressure.
module bf_delay_line #(
    parameter int DATA_W    = 19,
    parameter int MAX_DELAY = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_we,
    input  logic [$clog2(MAX_DELAY)-1:0] i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [$clog2(MAX_DELAY)-1:0] i_raddr,
    output logic [DATA_W-1:0]            o_rdata
);

    logic [DATA_W-1:0] r_mem [MAX_DELAY];

    // Clearing on reset makes reads of not-yet-written history return 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/delay_sum_beamformer.sv
// Steerable delay-and-sum: per-channel delayed samples summed serially over NUM_CH cycles.
// Latency NUM_CH+1 cycles to out_valid. No backpressure: frames arriving while busy are dropped and flag overrun.
module delay_sum_beamformer
    import bf_pkg::*;
#(
    parameter int NUM_CH    = 16,
    parameter int DATA_W    = 19,
    parameter int MAX_DELAY = 32,
    parameter int DELAY_W   = $clog2(MAX_DELAY),
    parameter int OUT_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic                       cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [DELAY_W-1:0]         cfg_delay,
    input  logic                       cfg_commit,
    output logic                       busy,
    output logic                       overrun,
    output logic                       out_valid,
    output logic [OUT_W-1:0]           out_data
);

    localparam int SUM_W = sum_width(DATA_W, NUM_CH);
    localparam int IDX_W = idx_width(NUM_CH);

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [DELAY_W-1:0]        r_wr_ptr;
    logic [DELAY_W-1:0]        r_rd_base;
    logic [DELAY_W-1:0]        r_shadow [NUM_CH];
    logic [DELAY_W-1:0]        r_active [NUM_CH];
    logic                      r_pending;
    logic [NUM_CH-1:0]         r_en;
    logic signed [SUM_W-1:0]   r_acc;
    logic                      r_overrun;
    logic                      r_out_valid;
    logic [OUT_W-1:0]          r_out_data;

    logic                      w_accept;
    logic [DELAY_W-1:0]        w_shadow_nxt [NUM_CH];
    logic [DELAY_W-1:0]        w_raddr [NUM_CH];
    logic signed [DATA_W-1:0]  w_rd [NUM_CH];
    logic signed [DATA_W-1:0]  w_sel;
    logic signed [SUM_W-1:0]   w_term;
    logic signed [SUM_W-1:0]   w_acc_nxt;

    assign w_accept = (r_state == IDLE) && in_valid;

    // A cfg write in the same cycle as a commit copy must be part of that copy.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (cfg_we) begin
            w_shadow_nxt[cfg_ch] = cfg_delay;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_line
        assign w_raddr[k] = r_rd_base - r_active[k];

        bf_delay_line #(
            .DATA_W    (DATA_W),
            .MAX_DELAY (MAX_DELAY)
        ) u_line (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_we    (w_accept),
            .i_waddr (r_wr_ptr),
            .i_wdata (in_data[k*DATA_W +: DATA_W]),
            .i_raddr (w_raddr[k]),
            .o_rdata (w_rd[k])
        );
    end

    assign w_sel     = w_rd[r_idx];
    assign w_term    = r_en[r_idx] ? SUM_W'(w_sel) : '0;
    assign w_acc_nxt = r_acc + w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_wr_ptr    <= '0;
            r_rd_base   <= '0;
            r_pending   <= 1'b0;
            r_en        <= '0;
            r_acc       <= '0;
            r_overrun   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_shadow    <= w_shadow_nxt;
            r_out_valid <= 1'b0;
            if (cfg_commit) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state   <= ACCUM;
                        r_idx     <= '0;
                        r_rd_base <= r_wr_ptr;
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_en      <= ch_enable;
                        r_acc     <= '0;
                        // Steering only changes here, so one output never mixes delay sets.
                        if (r_pending) begin
                            r_active  <= w_shadow_nxt;
                            r_pending <= cfg_commit;
                        end
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_nxt;
                    if (in_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (r_idx == IDX_W'(NUM_CH - 1)) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= OUT_W'(w_acc_nxt);
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_delay_sum_beamformer.sv
// Randomised and directed bench for delay_sum_beamformer against a frame-history model.
module tb_delay_sum_beamformer;

    localparam int NUM_CH    = 16;
    localparam int DATA_W    = 19;
    localparam int MAX_DELAY = 32;
    localparam int DELAY_W   = 5;
    localparam int OUT_W     = 32;
    localparam int CH_W      = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     in_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        ch_enable = '0;
    logic                     cfg_we = 1'b0;
    logic [CH_W-1:0]          cfg_ch = '0;
    logic [DELAY_W-1:0]       cfg_delay = '0;
    logic                     cfg_commit = 1'b0;
    logic                     busy;
    logic                     overrun;
    logic                     out_valid;
    logic [OUT_W-1:0]         out_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: every accepted frame since reset, plus shadow/active steering.
    int hist [0:255][0:NUM_CH-1];
    int hcount;
    int m_shadow [NUM_CH];
    int m_active [NUM_CH];
    bit m_pending;

    delay_sum_beamformer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .MAX_DELAY(MAX_DELAY),
        .DELAY_W(DELAY_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .ch_enable(ch_enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_delay(cfg_delay), .cfg_commit(cfg_commit), .busy(busy),
        .overrun(overrun), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        hcount    = 0;
        m_pending = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            m_shadow[k] = 0;
            m_active[k] = 0;
        end
    endfunction

    function automatic int model_frame(input logic [NUM_CH*DATA_W-1:0] d,
                                       input logic [NUM_CH-1:0] m);
        int sum;
        int src;
        logic signed [DATA_W-1:0] s;
        if (m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            s = d[k*DATA_W +: DATA_W];
            hist[hcount][k] = int'(s);
        end
        sum = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            src = hcount - m_active[k];
            if (m[k] && src >= 0) sum += hist[src][k];
        end
        hcount++;
        return sum;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] fill(input int v);
        logic [NUM_CH*DATA_W-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(v);
        return f;
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] rand_frame();
        logic [NUM_CH*DATA_W-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'($urandom);
        return f;
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input int ch, input int d, input bit commit);
        cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_delay = DELAY_W'(d); cfg_commit = commit;
        @(posedge clk);
        m_shadow[ch] = d;
        if (commit) m_pending = 1'b1;
        #1 cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    // Drives one frame from an idle DUT and waits (bounded) for its result.
    task automatic run_frame(input logic [NUM_CH*DATA_W-1:0] d, input logic [NUM_CH-1:0] m,
                             output int exp, output logic [OUT_W-1:0] got,
                             output int lat, output int bcnt, output bit tmo);
        in_data = d; ch_enable = m; in_valid = 1'b1;
        exp = model_frame(d, m);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1; bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1 lat++;
        end
        tmo = !out_valid;
        got = out_data;
    endtask

    task automatic test_reset();
        int seen;
        do_reset();
        n_checks += 4;
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (overrun !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        if (out_data !== '0)   begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        in_data = fill(1); ch_enable = '1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        do_reset();
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        n_checks += 2;
        if (seen != 0)     begin n_fail++; $display("FAIL reset_abort out_valid_pulses=%0d exp=0", seen); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_all_ones();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        do_reset();
        run_frame(fill(1), '1, exp, got, lat, bcnt, tmo);
        n_checks += 4;
        if (tmo || lat != 17) begin n_fail++; $display("FAIL ones_latency got=%0d exp=17", lat); end
        if (got !== 32'd16)   begin n_fail++; $display("FAIL ones_sum got=%0d exp=16", got); end
        if (bcnt != 16)       begin n_fail++; $display("FAIL ones_busy_cycles got=%0d exp=16", bcnt); end
        if (busy !== 1'b0)    begin n_fail++; $display("FAIL ones_busy_at_out got=%b exp=0", busy); end
        @(posedge clk);
        #1 n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd16) begin
            n_fail++; $display("FAIL ones_hold valid=%b data=%0d exp valid=0 data=16", out_valid, out_data);
        end
    endtask

    task automatic test_neg_full();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        do_reset();
        run_frame(fill(-262144), '1, exp, got, lat, bcnt, tmo);
        n_checks++;
        if (tmo || got !== 32'hFFC00000) begin
            n_fail++; $display("FAIL neg_full got=%h exp=ffc00000", got);
        end
    endtask

    task automatic test_delay_ch3();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        logic [NUM_CH*DATA_W-1:0] f;
        int req [3] = '{0, 0, 10};
        do_reset();
        cfg_write(3, 2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            f = '0;
            f[3*DATA_W +: DATA_W] = DATA_W'(10 * (i + 1));
            run_frame(f, '1, exp, got, lat, bcnt, tmo);
            n_checks++;
            if (tmo || got !== OUT_W'(req[i])) begin
                n_fail++; $display("FAIL delay_ch3[%0d] got=%0d exp=%0d", i, got, req[i]);
            end
        end
    endtask

    task automatic test_commit_mid();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        logic [NUM_CH*DATA_W-1:0] f;
        do_reset();
        f = fill(1); f[0 +: DATA_W] = DATA_W'(5);
        in_data = f; ch_enable = '1; in_valid = 1'b1;
        exp = model_frame(f, '1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 cfg_write(0, 1, 1'b1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if (!out_valid || out_data !== 32'd20) begin
            n_fail++; $display("FAIL commit_mid_old got=%0d exp=20 (model %0d)", out_data, exp);
        end
        f = fill(2); f[0 +: DATA_W] = DATA_W'(7);
        run_frame(f, '1, exp, got, lat, bcnt, tmo);
        n_checks++;
        if (tmo || got !== 32'd35) begin
            n_fail++; $display("FAIL commit_mid_new got=%0d exp=35 (model %0d)", got, exp);
        end
    endtask

    task automatic test_overrun();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        do_reset();
        cfg_write(1, 1, 1'b1);
        in_data = fill(3); ch_enable = '1; in_valid = 1'b1;
        exp = model_frame(fill(3), '1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 in_data = fill(100); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks += 2;
        if (!out_valid || out_data !== OUT_W'(exp)) begin
            n_fail++; $display("FAIL overrun_first got=%0d exp=%0d", out_data, exp);
        end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        run_frame(fill(2), '1, exp, got, lat, bcnt, tmo);
        n_checks += 2;
        if (tmo || got !== OUT_W'(exp) || exp != 33) begin
            n_fail++; $display("FAIL overrun_next got=%0d exp=%0d", got, exp);
        end
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_wrap();
        int exp, lat, bcnt, req, errs; logic [OUT_W-1:0] got; bit tmo;
        logic [NUM_CH*DATA_W-1:0] f;
        do_reset();
        cfg_write(0, 31, 1'b1);
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            f = rand_frame();
            f[0 +: DATA_W] = DATA_W'(i + 1);
            run_frame(f, 16'h0001, exp, got, lat, bcnt, tmo);
            req = (i < 31) ? 0 : i - 30;
            n_checks++;
            if (tmo || got !== OUT_W'(req)) begin
                n_fail++; $display("FAIL wrap[%0d] got=%0d exp=%0d", i, got, req);
            end
        end
    endtask

    task automatic test_random();
        int exp, lat, bcnt; logic [OUT_W-1:0] got; bit tmo;
        logic [NUM_CH-1:0] m;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_write($urandom_range(0, NUM_CH - 1), $urandom_range(0, MAX_DELAY - 1),
                          1'($urandom_range(0, 1)));
            end
            m = NUM_CH'($urandom);
            run_frame(rand_frame(), m, exp, got, lat, bcnt, tmo);
            n_checks += 2;
            if (tmo || lat != 17) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d exp=17", i, lat); end
            if (got !== OUT_W'(exp)) begin
                n_fail++; $display("FAIL rand_sum[%0d] got=%h exp=%h", i, got, OUT_W'(exp));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_all_ones();
        test_neg_full();
        test_delay_ch3();
        test_commit_mid();
        test_overrun();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
